// File: rtl/ula_pkg.sv
// Shared types and constants for the ALU sequencer: opcodes, ALU selectors,
// FSM state encoding and register-file geometry.
package ula_pkg;

  localparam int unsigned RegAddrW = 2;
  localparam int unsigned DataW    = 4;
  localparam int unsigned NumRegs  = 4;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_LDI  = 4'b0001;
  localparam logic [3:0] OP_MOV  = 4'b0010;
  localparam logic [3:0] OP_RSVD = 4'b0011;

  // ALU selectors; ADD and SUB ignore the two low bits.
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NAND = 4'b0111;
  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b1100;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StWb
  } state_e;

  function automatic logic is_alu_op(input logic [3:0] op);
    return op[3:2] != 2'b00;
  endfunction

endpackage

// File: rtl/ula_regfile.sv
// 4x4-bit register file: one synchronous write port with synchronous active-low
// clear, three combinational read ports.
module ula_regfile
  import ula_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                we_i,
  input  logic [RegAddrW-1:0] waddr_i,
  input  logic [DataW-1:0]    wdata_i,
  input  logic [RegAddrW-1:0] rs_addr_i,
  output logic [DataW-1:0]    rs_data_o,
  input  logic [RegAddrW-1:0] rt_addr_i,
  output logic [DataW-1:0]    rt_data_o,
  input  logic [RegAddrW-1:0] dbg_addr_i,
  output logic [DataW-1:0]    dbg_data_o
);

  logic [DataW-1:0] regs_q [NumRegs];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rs_data_o  = regs_q[rs_addr_i];
  assign rt_data_o  = regs_q[rt_addr_i];
  assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/ula_seq_ctrl.sv
// Single-issue sequencer for the 4-bit ALU: accept, issue, wait for ack, write back.
// Optional ULA_SEQ_FLAGS_EN adds a zero_flag output updated by ALU writebacks.
module ula_seq_ctrl
  import ula_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [3:0]          instr_op,
  input  logic [RegAddrW-1:0] instr_rd,
  input  logic [RegAddrW-1:0] instr_rs,
  input  logic [RegAddrW-1:0] instr_rt,
  input  logic [DataW-1:0]    instr_imm,
  output logic                ula_enable,
  output logic [DataW-1:0]    ula_a,
  output logic [DataW-1:0]    ula_b,
  output logic [3:0]          ula_sel,
  input  logic [DataW-1:0]    ula_result,
  input  logic                ula_ack,
  output logic                done,
  output logic [DataW-1:0]    done_data,
  output logic                err,
  input  logic [RegAddrW-1:0] dbg_addr,
  output logic [DataW-1:0]    dbg_data
`ifdef ULA_SEQ_FLAGS_EN
  ,
  output logic                zero_flag
`endif
);

  state_e              state_q, state_d;
  logic [3:0]          op_q, op_d;
  logic [RegAddrW-1:0] rd_q, rd_d;
  logic [DataW-1:0]    imm_q, imm_d;
  logic [DataW-1:0]    a_q, a_d;
  logic [DataW-1:0]    b_q, b_d;
  logic [DataW-1:0]    res_q, res_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                err_q, err_d;

  logic [DataW-1:0]    rs_data, rt_data;
  logic                rf_we;
  logic [3:0]          cnt_inc;

  ula_regfile u_regfile (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .we_i       (rf_we),
    .waddr_i    (rd_q),
    .wdata_i    (done_data),
    .rs_addr_i  (instr_rs),
    .rs_data_o  (rs_data),
    .rt_addr_i  (instr_rt),
    .rt_data_o  (rt_data),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  assign cnt_inc = cnt_q + 4'd1;
  assign err     = err_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    imm_d       = imm_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    cnt_d       = cnt_q;
    err_d       = 1'b0;
    instr_ready = 1'b0;
    ula_enable  = 1'b0;
    ula_a       = '0;
    ula_b       = '0;
    ula_sel     = '0;
    done        = 1'b0;
    done_data   = '0;
    rf_we       = 1'b0;

    unique case (state_q)
      StIdle: begin
        instr_ready = rst_n;
        if (instr_valid) begin
          op_d    = instr_op;
          rd_d    = instr_rd;
          imm_d   = instr_imm;
          a_d     = rs_data;
          b_d     = rt_data;
          state_d = is_alu_op(instr_op) ? StIssue : StWb;
        end
      end
      StIssue: begin
        ula_enable = 1'b1;
        ula_a      = a_q;
        ula_b      = b_q;
        ula_sel    = op_q;
        cnt_d      = '0;
        state_d    = StWait;
      end
      StWait: begin
        ula_a   = a_q;
        ula_b   = b_q;
        ula_sel = op_q;
        if (ula_ack) begin
          res_d   = ula_result;
          cnt_d   = '0;
          state_d = StWb;
        end else if (cnt_inc == 4'(ACK_TIMEOUT)) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StWb: begin
        done    = 1'b1;
        state_d = StIdle;
        if (op_q == OP_LDI) begin
          done_data = imm_q;
          rf_we     = 1'b1;
        end else if (op_q == OP_MOV) begin
          done_data = a_q;
          rf_we     = 1'b1;
        end else if (is_alu_op(op_q)) begin
          done_data = res_q;
          rf_we     = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      imm_q   <= imm_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

`ifdef ULA_SEQ_FLAGS_EN
  logic zero_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
    end else if (state_q == StWb && is_alu_op(op_q)) begin
      zero_q <= (res_q == '0);
    end
  end

  assign zero_flag = zero_q;
`endif

endmodule

// File: tb/tb_ula_seq_ctrl.sv
// Self-checking bench for ula_seq_ctrl: directed test-plan sequences plus random
// instructions checked against a register-level reference model and ALU model.
module tb_ula_seq_ctrl;

  localparam int AckTimeout = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] instr_op;
  logic [1:0] instr_rd, instr_rs, instr_rt;
  logic [3:0] instr_imm;
  logic       ula_enable;
  logic [3:0] ula_a, ula_b, ula_sel, ula_result;
  logic       ula_ack;
  logic       done;
  logic [3:0] done_data;
  logic       err;
  logic [1:0] dbg_addr;
  logic [3:0] dbg_data;
`ifdef ULA_SEQ_FLAGS_EN
  logic       zero_flag;
`endif

  logic       alu_ack, spurious_ack;
  logic [3:0] alu_res, spur_res;
  int         alu_delay = 1;
  bit         alu_noack = 0;

  int         n_checks = 0;
  int         n_errors = 0;
  int         n_done = 0;
  int         n_exp_done = 0;

  logic [3:0] mregs [4];
  logic       mzf;

  assign ula_ack    = alu_ack | spurious_ack;
  assign ula_result = spurious_ack ? spur_res : alu_res;

  always #5 clk = ~clk;

  ula_seq_ctrl #(.ACK_TIMEOUT(AckTimeout)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_rd    (instr_rd),
    .instr_rs    (instr_rs),
    .instr_rt    (instr_rt),
    .instr_imm   (instr_imm),
    .ula_enable  (ula_enable),
    .ula_a       (ula_a),
    .ula_b       (ula_b),
    .ula_sel     (ula_sel),
    .ula_result  (ula_result),
    .ula_ack     (ula_ack),
    .done        (done),
    .done_data   (done_data),
    .err         (err),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
`ifdef ULA_SEQ_FLAGS_EN
    ,
    .zero_flag   (zero_flag)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_alu(input logic [3:0] sel, input logic [3:0] a,
                                         input logic [3:0] b);
    case (sel[3:2])
      2'b10: return a + b;
      2'b11: return a - b;
      2'b01: begin
        case (sel[1:0])
          2'd0:    return a | b;
          2'd1:    return a & b;
          2'd2:    return a ^ b;
          default: return ~(a & b);
        endcase
      end
      default: return 4'd0;
    endcase
  endfunction

  // Behavioural ALU: acks alu_delay cycles after it sees enable.
  initial begin
    logic [3:0] r;
    alu_ack = 1'b0;
    alu_res = 4'd0;
    forever begin
      @(posedge clk); #1;
      if (ula_enable === 1'b1 && !alu_noack) begin
        r = ref_alu(ula_sel, ula_a, ula_b);
        repeat (alu_delay) begin @(posedge clk); #1; end
        alu_res = r;
        alu_ack = 1'b1;
        @(posedge clk); #1;
        alu_ack = 1'b0;
        alu_res = 4'($urandom);
      end
    end
  end

  always @(negedge clk) if (rst_n === 1'b1 && done === 1'b1) n_done++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      check(tag, dbg_data, mregs[i]);
    end
  endtask

  task automatic exec(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                      input logic [1:0] rt, input logic [3:0] imm, input bit hold);
    int         k;
    int         cyc;
    int         done_cyc;
    int         err_cyc;
    int         en_cnt;
    bit         is_alu;
    bit         exp_to;
    bit         writes;
    logic [3:0] exp_val;
    logic [3:0] old;

    is_alu  = (op[3:2] != 2'b00);
    exp_to  = is_alu && alu_noack;
    writes  = (op == 4'd1 || op == 4'd2 || is_alu) && !exp_to;
    exp_val = (op == 4'd1) ? imm : (op == 4'd2) ? mregs[rs] :
              is_alu ? ref_alu(op, mregs[rs], mregs[rt]) : 4'd0;
    old     = mregs[rd];

    k = 0;
    while (instr_ready !== 1'b1 && k < 50) begin step(); k++; end
    check("ready_wait", instr_ready, 1);

    instr_op    = op;
    instr_rd    = rd;
    instr_rs    = rs;
    instr_rt    = rt;
    instr_imm   = imm;
    instr_valid = 1'b1;
    dbg_addr    = rd;
    step();
    if (!hold) begin
      instr_valid = 1'b0;
      instr_op    = 4'($urandom);
      instr_rs    = 2'($urandom);
      instr_rt    = 2'($urandom);
      instr_imm   = 4'($urandom);
    end

    cyc = 1; done_cyc = 0; err_cyc = 0; en_cnt = 0;
    while (cyc <= 40 && done_cyc == 0 && err_cyc == 0) begin
      if (ula_enable === 1'b1) begin
        en_cnt++;
        check("ula_a", ula_a, mregs[rs]);
        check("ula_b", ula_b, mregs[rt]);
        check("ula_sel", ula_sel, op);
      end
      if (done === 1'b1) begin
        done_cyc = cyc;
        check("done_data", done_data, exp_val);
        check("dbg_old_in_wb", dbg_data, old);
      end
      if (err === 1'b1) err_cyc = cyc;
      if (done_cyc == 0 && err_cyc == 0) begin step(); cyc++; end
    end

    check("enable_pulses", en_cnt, is_alu);
    if (exp_to) begin
      check("err_cycle", err_cyc, AckTimeout + 2);
      check("no_done_on_timeout", done_cyc, 0);
      check("ready_at_err", instr_ready, 1);
      check("rd_unchanged", dbg_data, old);
    end else begin
      check("done_cycle", done_cyc, is_alu ? 2 + alu_delay : 1);
      check("no_err", err_cyc, 0);
      n_exp_done++;
    end

    if (writes) mregs[rd] = exp_val;
    if (is_alu && !exp_to) mzf = (exp_val == 4'd0);

    if (!exp_to) begin
      step();
      check("ready_after_done", instr_ready, 1);
      check("dbg_after_wb", dbg_data, mregs[rd]);
    end
`ifdef ULA_SEQ_FLAGS_EN
    check("zero_flag", zero_flag, mzf);
`endif
  endtask

  initial begin
    bit hold;
    logic [3:0] op;

    rst_n        = 1'b0;
    instr_valid  = 1'b0;
    instr_op     = '0;
    instr_rd     = '0;
    instr_rs     = '0;
    instr_rt     = '0;
    instr_imm    = '0;
    dbg_addr     = '0;
    spurious_ack = 1'b0;
    spur_res     = '0;
    mzf          = 1'b0;
    for (int i = 0; i < 4; i++) mregs[i] = 4'd0;

    // Reset state
    step();
    step();
    check("ready_in_reset", instr_ready, 0);
    check("rst_enable", ula_enable, 0);
    check("rst_ula_a", ula_a, 0);
    check("rst_ula_b", ula_b, 0);
    check("rst_ula_sel", ula_sel, 0);
    check("rst_done", done, 0);
    check("rst_done_data", done_data, 0);
    check("rst_err", err, 0);
`ifdef ULA_SEQ_FLAGS_EN
    check("rst_zero_flag", zero_flag, 0);
`endif
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", instr_ready, 1);
    check_regs("rst_regs");

    // Load and add
    exec(4'b0001, 2'd1, 2'd0, 2'd0, 4'd5, 0);
    exec(4'b0001, 2'd2, 2'd0, 2'd0, 4'd3, 0);
    exec(4'b1000, 2'd3, 2'd1, 2'd2, 4'd0, 0);
    dbg_addr = 2'd3; #1;
    check("add_r3", dbg_data, 8);

    // Wrap-around subtract, then zero result
    exec(4'b0001, 2'd0, 2'd0, 2'd0, 4'd9, 0);
    exec(4'b0001, 2'd1, 2'd0, 2'd0, 4'd12, 0);
    exec(4'b1100, 2'd2, 2'd0, 2'd1, 4'd0, 0);
    dbg_addr = 2'd2; #1;
    check("sub_wrap_r2", dbg_data, 4'b1101);
    exec(4'b1100, 2'd3, 2'd0, 2'd0, 4'd0, 0);
    dbg_addr = 2'd3; #1;
    check("sub_zero_r3", dbg_data, 0);

    // Logic ops with rd aliasing a source
    exec(4'b0001, 2'd1, 2'd0, 2'd0, 4'hA, 0);
    exec(4'b0001, 2'd2, 2'd0, 2'd0, 4'h6, 0);
    exec(4'b0110, 2'd1, 2'd1, 2'd2, 4'd0, 0);
    dbg_addr = 2'd1; #1;
    check("xor_alias_r1", dbg_data, 4'hC);
    exec(4'b0001, 2'd1, 2'd0, 2'd0, 4'hA, 0);
    exec(4'b0111, 2'd0, 2'd1, 2'd2, 4'd0, 0);
    dbg_addr = 2'd0; #1;
    check("nand_r0", dbg_data, 4'hD);

    // MOV, NOP, reserved opcode
    exec(4'b0010, 2'd3, 2'd2, 2'd0, 4'd0, 0);
    exec(4'b0000, 2'd2, 2'd1, 2'd1, 4'hF, 0);
    exec(4'b0011, 2'd1, 2'd2, 2'd3, 4'hF, 0);
    check_regs("regs_after_nop");

    // Handshake with instr_valid held high across instructions
    exec(4'b0001, 2'd0, 2'd0, 2'd0, 4'd1, 1);
    exec(4'b0001, 2'd1, 2'd0, 2'd0, 4'd2, 1);
    exec(4'b1000, 2'd2, 2'd0, 2'd1, 4'd0, 1);
    exec(4'b0000, 2'd2, 2'd0, 2'd0, 4'd0, 1);
    exec(4'b0010, 2'd3, 2'd2, 2'd0, 4'd0, 1);
    instr_valid = 1'b0;
    dbg_addr = 2'd3; #1;
    check("hold_chain_r3", dbg_data, 3);

    // Timeout, then a stale ack in IDLE
    alu_noack = 1;
    exec(4'b1000, 2'd3, 2'd0, 2'd1, 4'd0, 0);
    alu_noack = 0;
    spurious_ack = 1'b1;
    spur_res     = 4'hE;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stale_ack_no_done", done, 0);
      check("stale_ack_ready", instr_ready, 1);
    end
    spurious_ack = 1'b0;
    check_regs("regs_after_stale_ack");

    // Reset while waiting for ack
    alu_noack = 1;
    instr_op = 4'b0101; instr_rd = 2'd0; instr_rs = 2'd1; instr_rt = 2'd2;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("ready_low_in_reset", instr_ready, 0);
    step();
    check("ready_low_after_rst_edge", instr_ready, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) mregs[i] = 4'd0;
    mzf = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("rst_wait_no_done", done, 0);
      check("rst_wait_no_err", err, 0);
      step();
    end
    check("ready_after_rst_wait", instr_ready, 1);
    check_regs("regs_after_rst_wait");
`ifdef ULA_SEQ_FLAGS_EN
    check("zero_after_rst_wait", zero_flag, 0);
`endif
    alu_noack = 0;

    // Random instructions against the model
    for (int n = 0; n < 60; n++) begin
      op        = 4'($urandom_range(0, 15));
      alu_delay = $urandom_range(1, AckTimeout);
      alu_noack = ($urandom_range(0, 9) == 0);
      hold      = !alu_noack && ($urandom_range(0, 3) == 0);
      exec(op, 2'($urandom), 2'($urandom), 2'($urandom), 4'($urandom), hold);
    end
    instr_valid = 1'b0;
    alu_noack   = 0;
    alu_delay   = 1;
    check_regs("regs_after_random");

    step();
    step();
    check("done_pulse_count", n_done, n_exp_done);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
